id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline. It sits directly downstream of the decode controller and latches that controller's control bundle plus decoded operands into the EX stage.
- It owns load-use hazard detection. On a hazard it stalls PC and IF/ID and inserts a bubble into EX.
- It honours an EX-stage flush on a taken branch or jump.
- It keeps a saturating count of inserted load-use bubbles for performance debug.

Parameters:
- DATA_W, 32, width of register operands and immediate
- PC_W, 32, width of the program counter
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  taken branch/jal/jalr resolved in EX; kill the instruction in ID
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  7  opcode of the ID instruction
- id_ALUSrc, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jal_Sel, id_Jalr_Sel  in  1 each  decoder control outputs
- id_MemtoReg  in  2  decoder control output
- id_ALUOp  in  3  decoder control output
- id_pc  in  PC_W  PC of the ID instruction
- id_rd1, id_rd2, id_imm  in  DATA_W  register-file read data and immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct3  in  3  funct3 field
- id_funct7  in  7  funct7 field
- ex_* (one per id_* above except id_opcode, plus ex_valid)  out  same widths  registered EX-stage copies
- stall  out  1  load-use stall asserted this cycle
- pc_write  out  1  equals ~stall
- if_id_write  out  1  equals ~stall
- bubble_count  out  CNT_W  number of load-use bubbles inserted since reset

Behaviour:
- Opcodes in use:
  - R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BR 1100011, JAL 1101111, JALR 1100111
  - Any other opcode counts as using no source register.
- Source usage:
  - uses_rs1 = id_valid and opcode in {R, I, LOAD, STORE, BR, JALR}
  - uses_rs2 = id_valid and opcode in {R, STORE, BR}
- Hazard (combinational, from registered EX state):
  - hazard = ex_valid & ex_MemRead & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2))
  - stall = hazard & ~flush. A flush kills the ID instruction, so no stall is raised in that cycle.
- Register update priority at each rising edge:
  1. reset: all ex_* outputs = 0, ex_valid = 0, bubble_count = 0.
  2. flush: load a bubble.
  3. stall: load a bubble; bubble_count increments.
  4. otherwise: capture every id_* into ex_*; ex_valid = id_valid.
- Bubble contents: every control output = 0 (ALUSrc, MemtoReg = 00, RegWrite, MemRead, MemWrite, ALUOp = 000, Branch, Jal_Sel, Jalr_Sel), ex_valid = 0, and all data/index fields = 0. Bubbles are fully deterministic.
- When id_valid = 0 in normal capture: control outputs are forced to 0 as for a bubble, but data fields are still captured.
- Latency: one cycle from ID inputs to ex_* outputs.
  - stall/pc_write/if_id_write are same-cycle combinational outputs.
  - stall lasts exactly one cycle per load-use pair, because the bubble clears ex_MemRead.
- bubble_count:
  - Increments only on cycles where a stall bubble is inserted; flush bubbles are not counted.
  - Saturates at all-ones (2^CNT_W - 1) with no wrap.
- Simultaneous flush and hazard: flush wins; stall = 0, pc_write = 1, no count.
- Reset asserted mid-stall: reset wins; stall deasserts in the cycle after reset because ex_valid = 0.
- x0 never creates a hazard, even if a load targets rd = 0.

Test Plan:
- Reset: hold reset 2 cycles with random id_* values -> all ex_* = 0, stall = 0, pc_write = 1, bubble_count = 0.
- Pass-through: id = add x3,x1,x2 (opcode 0110011, RegWrite = 1, ALUOp = 010, rd1 = 5, rd2 = 7) -> next cycle ex_RegWrite = 1, ex_ALUOp = 010, ex_rd1 = 5, ex_rd2 = 7, ex_rd = 3, ex_valid = 1.
- Load-use: lw x5 in EX, then add x6,x5,x1 in ID -> stall = 1 and pc_write = 0 for exactly 1 cycle; next EX holds a bubble (RegWrite = 0, ex_valid = 0); add enters EX one cycle later; bubble_count = 1.
- No false hazard:
  - lw x0 followed by a user of x0 -> stall = 0.
  - lw x5 followed by jal x1 (rs1 field = 5) -> stall = 0.
  - lw x5 followed by addi using rs2 field = 5 -> stall = 0.
  - sw with rs2 = x5 after lw x5 -> stall = 1.
- Flush vs hazard: load-use condition with flush = 1 in the same cycle -> stall = 0, next EX is a bubble, bubble_count unchanged.
- Saturation: CNT_W = 4, generate 17 load-use stalls -> bubble_count stops at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I pipeline.
// Also detects load-use hazards, inserts bubbles and counts stall bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_Jal_Sel,
  input  logic              id_Jalr_Sel,
  input  logic [1:0]        id_MemtoReg,
  input  logic [2:0]        id_ALUOp,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  output logic              ex_valid,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_Jal_Sel,
  output logic              ex_Jalr_Sel,
  output logic [1:0]        ex_MemtoReg,
  output logic [2:0]        ex_ALUOp,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic              valid;
    logic              aluSrc;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              branch;
    logic              jalSel;
    logic              jalrSel;
    logic [1:0]        memtoReg;
    logic [2:0]        aluOp;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
  } exBundle_t;

  exBundle_t         bundle_d, bundle_q;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              usesRs1, usesRs2, hazard;

  always_comb begin
    usesRs1 = id_valid && (id_opcode == OP_R || id_opcode == OP_I ||
                           id_opcode == OP_LOAD || id_opcode == OP_STORE ||
                           id_opcode == OP_BR || id_opcode == OP_JALR);
    usesRs2 = id_valid && (id_opcode == OP_R || id_opcode == OP_STORE ||
                           id_opcode == OP_BR);
    hazard  = bundle_q.valid && bundle_q.memRead && (bundle_q.rd != 5'd0) &&
              ((usesRs1 && bundle_q.rd == id_rs1) ||
               (usesRs2 && bundle_q.rd == id_rs2));
    // A flush kills the ID instruction, so it can never need to wait.
    stall       = hazard && !flush;
    pc_write    = !stall;
    if_id_write = !stall;
  end

  always_comb begin
    bundle_d = '0;
    count_d  = count_q;
    if (!flush && !stall) begin
      bundle_d.pc     = id_pc;
      bundle_d.rd1    = id_rd1;
      bundle_d.rd2    = id_rd2;
      bundle_d.imm    = id_imm;
      bundle_d.rs1    = id_rs1;
      bundle_d.rs2    = id_rs2;
      bundle_d.rd     = id_rd;
      bundle_d.funct3 = id_funct3;
      bundle_d.funct7 = id_funct7;
      if (id_valid) begin
        bundle_d.valid    = 1'b1;
        bundle_d.aluSrc   = id_ALUSrc;
        bundle_d.regWrite = id_RegWrite;
        bundle_d.memRead  = id_MemRead;
        bundle_d.memWrite = id_MemWrite;
        bundle_d.branch   = id_Branch;
        bundle_d.jalSel   = id_Jal_Sel;
        bundle_d.jalrSel  = id_Jalr_Sel;
        bundle_d.memtoReg = id_MemtoReg;
        bundle_d.aluOp    = id_ALUOp;
      end
    end
    if (stall && count_q != {CNT_W{1'b1}})
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q <= '0;
      count_q  <= '0;
    end else begin
      bundle_q <= bundle_d;
      count_q  <= count_d;
    end
  end

  assign ex_valid     = bundle_q.valid;
  assign ex_ALUSrc    = bundle_q.aluSrc;
  assign ex_RegWrite  = bundle_q.regWrite;
  assign ex_MemRead   = bundle_q.memRead;
  assign ex_MemWrite  = bundle_q.memWrite;
  assign ex_Branch    = bundle_q.branch;
  assign ex_Jal_Sel   = bundle_q.jalSel;
  assign ex_Jalr_Sel  = bundle_q.jalrSel;
  assign ex_MemtoReg  = bundle_q.memtoReg;
  assign ex_ALUOp     = bundle_q.aluOp;
  assign ex_pc        = bundle_q.pc;
  assign ex_rd1       = bundle_q.rd1;
  assign ex_rd2       = bundle_q.rd2;
  assign ex_imm       = bundle_q.imm;
  assign ex_rs1       = bundle_q.rs1;
  assign ex_rs2       = bundle_q.rs2;
  assign ex_rd        = bundle_q.rd;
  assign ex_funct3    = bundle_q.funct3;
  assign ex_funct7    = bundle_q.funct7;
  assign bubble_count = count_q;

endmodule
